dual_port_ram_be: RTL and testbench

Parametrised simple dual-port synchronous RAM: one write port with per-byte write enables, one read port, selectable read latency, selectable read-during-write behaviour and a hardware clear sequencer. After reset it clears every entry, not a subset. It is the general-purpose buffer memory for datapath blocks, replacing the fixed 8-bit single-latency RAM.

---
 rtl/dual_port_ram_be_if.sv | 27 ++
 rtl/dual_port_ram_be.sv | 125 ++++++++++++
 tb/tb_dual_port_ram_be.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_be_if.sv
// Request/response bundle for dual_port_ram_be: write port, read port and status.
// The master drives requests; the RAM (slave) returns read data and busy status.
interface dual_port_ram_be_if #(
  parameter int ram_width  = 32,
  parameter int byte_width = 8,
  parameter int addr_size  = 8
);
  logic                             wr_enb;
  logic [addr_size-1:0]             wr_addr;
  logic [ram_width/byte_width-1:0]  wr_be;
  logic [ram_width-1:0]             data_in;
  logic                             rd_enb;
  logic [addr_size-1:0]             rd_addr;
  logic [ram_width-1:0]             data_out;
  logic                             rd_valid;
  logic                             init_busy;

  modport master (
    output wr_enb, wr_addr, wr_be, data_in, rd_enb, rd_addr,
    input  data_out, rd_valid, init_busy
  );

  modport slave (
    input  wr_enb, wr_addr, wr_be, data_in, rd_enb, rd_addr,
    output data_out, rd_valid, init_busy
  );
endinterface

// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with byte-lane write enables, 1- or 2-cycle read latency,
// selectable read-during-write result and a post-reset clear sequencer.
module dual_port_ram_be #(
  parameter int                   ram_width  = 32,
  parameter int                   byte_width = 8,
  parameter int                   ram_depth  = 256,
  parameter int                   addr_size  = 8,
  parameter int                   rd_latency = 1,
  parameter int                   rdw_mode   = 0,
  parameter logic [ram_width-1:0] init_value = '0
) (
  input logic               clk,
  input logic               reset,
  dual_port_ram_be_if.slave bus
);

  localparam int                   lanes_c     = ram_width / byte_width;
  localparam logic [addr_size:0]   depth_c     = (addr_size + 1)'(ram_depth);
  localparam logic [addr_size-1:0] last_addr_c = addr_size'(ram_depth - 1);

  typedef enum logic [1:0] {HOLD, CLEAR, READY} state_e;

  state_e               state_q, state_d;
  logic [addr_size-1:0] clr_cnt_q, clr_cnt_d;
  logic [ram_width-1:0] mem [ram_depth];

  logic                 busy;
  logic                 wr_fire, rd_fire;
  logic                 wr_in_range, rd_in_range;
  logic [ram_width-1:0] mem_rd, merged, rd_word;
  logic [ram_width-1:0] rd_data1_q;
  logic                 rd_valid1_q;

  assign busy        = !reset || (state_q != READY);
  assign wr_in_range = ({1'b0, bus.wr_addr} < depth_c);
  assign rd_in_range = ({1'b0, bus.rd_addr} < depth_c);
  assign wr_fire     = !busy && bus.wr_enb && wr_in_range;
  assign rd_fire     = !busy && bus.rd_enb;
  assign bus.init_busy = busy;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      HOLD: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == last_addr_c) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= HOLD;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: the array has no reset branch; the clear sequencer initialises it so it maps to RAM.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_cnt_q] <= init_value;
    end else if (wr_fire) begin
      for (int k = 0; k < lanes_c; k++) begin
        if (bus.wr_be[k])
          mem[bus.wr_addr][k*byte_width +: byte_width] <= bus.data_in[k*byte_width +: byte_width];
      end
    end
  end

  // Out-of-range reads return zero; merged word serves same-address new-data reads.
  always_comb begin
    mem_rd = '0;
    if (rd_in_range) mem_rd = mem[bus.rd_addr];
    merged = mem_rd;
    for (int k = 0; k < lanes_c; k++) begin
      if (bus.wr_be[k])
        merged[k*byte_width +: byte_width] = bus.data_in[k*byte_width +: byte_width];
    end
    rd_word = mem_rd;
    if (rdw_mode == 1 && wr_fire && bus.wr_addr == bus.rd_addr) rd_word = merged;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data1_q  <= '0;
      rd_valid1_q <= 1'b0;
    end else begin
      rd_valid1_q <= rd_fire;
      if (rd_fire) rd_data1_q <= rd_word;
    end
  end

  if (rd_latency == 2) begin : g_lat2
    logic [ram_width-1:0] rd_data2_q;
    logic                 rd_valid2_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        rd_data2_q  <= '0;
        rd_valid2_q <= 1'b0;
      end else begin
        rd_valid2_q <= rd_valid1_q;
        if (rd_valid1_q) rd_data2_q <= rd_data1_q;
      end
    end

    assign bus.data_out = rd_data2_q;
    assign bus.rd_valid = rd_valid2_q;
  end else begin : g_lat1
    assign bus.data_out = rd_data1_q;
    assign bus.rd_valid = rd_valid1_q;
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: four RAM configurations (default, new-data RDW, 2-cycle latency,
// 200-deep) share one stimulus stream; each output is compared to hand-computed values.
module tb_dual_port_ram_be;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_enb = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] data_in = '0;
  logic        rd_enb = 1'b0;
  logic [7:0]  rd_addr = '0;

  logic [31:0] dout [4];
  logic        vld  [4];
  logic        busy [4];

  int n_checks = 0;
  int n_pass   = 0;
  int c0, c3, spur;

  always #5 clk = ~clk;

  dual_port_ram_be_if bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_conn
    assign bus[g].wr_enb  = wr_enb;
    assign bus[g].wr_addr = wr_addr;
    assign bus[g].wr_be   = wr_be;
    assign bus[g].data_in = data_in;
    assign bus[g].rd_enb  = rd_enb;
    assign bus[g].rd_addr = rd_addr;
    assign dout[g] = bus[g].data_out;
    assign vld[g]  = bus[g].rd_valid;
    assign busy[g] = bus[g].init_busy;
  end

  dual_port_ram_be u0 (.clk(clk), .reset(reset), .bus(bus[0]));
  dual_port_ram_be #(.rdw_mode(1))   u1 (.clk(clk), .reset(reset), .bus(bus[1]));
  dual_port_ram_be #(.rd_latency(2)) u2 (.clk(clk), .reset(reset), .bus(bus[2]));
  dual_port_ram_be #(.ram_depth(200)) u3 (.clk(clk), .reset(reset), .bus(bus[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_addr = a; data_in = d; wr_be = be; wr_enb = 1'b1;
    cycle();
    wr_enb = 1'b0;
  endtask

  // Counts busy cycles of the 256- and 200-deep instances; optionally fires a
  // write+read at addr 12 on iteration attempt_at and counts any rd_valid seen.
  task automatic wait_clear(input int attempt_at, output int n0, output int n3, output int sp);
    n0 = 0; n3 = 0; sp = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == attempt_at) begin
        wr_addr = 8'd12; data_in = 32'hFFFF_FFFF; wr_be = 4'hF; wr_enb = 1'b1;
        rd_addr = 8'd12; rd_enb = 1'b1;
      end
      cycle();
      wr_enb = 1'b0; rd_enb = 1'b0;
      if (vld[0] || vld[2]) sp++;
      if (busy[0]) n0++;
      if (busy[3]) n3++;
      if (!busy[0] && !busy[3]) break;
    end
  endtask

  task automatic read_all(input logic [7:0] a, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3, input string tag);
    rd_addr = a; rd_enb = 1'b1;
    cycle();
    rd_enb = 1'b0;
    check({tag, " u0 valid"}, 32'(vld[0]), 32'd1);
    check({tag, " u0 data"},  dout[0], e0);
    check({tag, " u1 data"},  dout[1], e1);
    check({tag, " u3 valid"}, 32'(vld[3]), 32'd1);
    check({tag, " u3 data"},  dout[3], e3);
    check({tag, " u2 early valid"}, 32'(vld[2]), 32'd0);
    cycle();
    check({tag, " u2 valid"}, 32'(vld[2]), 32'd1);
    check({tag, " u2 data"},  dout[2], e2);
    check({tag, " u0 pulse end"}, 32'(vld[0]), 32'd0);
  endtask

  // Same-cycle write and read: e_old for old-data instances, e_new for u1.
  task automatic rw(input logic [7:0] wa, input logic [31:0] wd, input logic [3:0] be,
                    input logic [7:0] ra, input logic [31:0] e_old, input logic [31:0] e_new,
                    input string tag);
    wr_addr = wa; data_in = wd; wr_be = be; wr_enb = 1'b1;
    rd_addr = ra; rd_enb = 1'b1;
    cycle();
    wr_enb = 1'b0; rd_enb = 1'b0;
    check({tag, " u0 data"}, dout[0], e_old);
    check({tag, " u1 data"}, dout[1], e_new);
    check({tag, " u1 valid"}, 32'(vld[1]), 32'd1);
    check({tag, " u3 data"}, dout[3], e_old);
    cycle();
    check({tag, " u2 data"}, dout[2], e_old);
    check({tag, " u2 valid"}, 32'(vld[2]), 32'd1);
  endtask

  initial begin
    repeat (3) cycle();
    for (int g = 0; g < 4; g++) begin
      check($sformatf("reset busy u%0d", g), 32'(busy[g]), 32'd1);
      check($sformatf("reset data u%0d", g), dout[g], 32'd0);
      check($sformatf("reset valid u%0d", g), 32'(vld[g]), 32'd0);
    end

    reset = 1'b1;
    wait_clear(-1, c0, c3, spur);
    check("first clear len 256", c0, 256);
    check("first clear len 200", c3, 200);

    for (int i = 0; i < 256; i++) wr(8'(i), 32'hDEAD_BEEF, 4'hF);
    read_all(8'd100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "fill");

    reset = 1'b0;
    cycle();
    reset = 1'b1;
    wait_clear(-1, c0, c3, spur);
    check("clear len 256", c0, 256);
    check("clear len 200", c3, 200);
    read_all(8'd0,   '0, '0, '0, '0, "clr a0");
    read_all(8'd8,   '0, '0, '0, '0, "clr a8");
    read_all(8'd100, '0, '0, '0, '0, "clr a100");
    read_all(8'd255, '0, '0, '0, '0, "clr a255");

    wr(8'd5, 32'h1122_3344, 4'hF);
    wr(8'd5, 32'hAABB_CCDD, 4'b0101);
    wr(8'd5, 32'hFFFF_FFFF, 4'b0000);
    read_all(8'd5, 32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD, "byte en");

    rw(8'd9, 32'hCAFE_F00D, 4'hF, 8'd9, 32'h0, 32'hCAFE_F00D, "rdw full");
    read_all(8'd9, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, "rdw after");
    rw(8'd10, 32'h1234_5678, 4'b0011, 8'd10, 32'h0, 32'h0000_5678, "rdw merge");
    read_all(8'd10, 32'h0000_5678, 32'h0000_5678, 32'h0000_5678, 32'h0000_5678, "merge after");
    rw(8'd20, 32'h0000_2020, 4'hF, 8'd5, 32'h11BB_33DD, 32'h11BB_33DD, "diff addr");
    read_all(8'd20, 32'h2020, 32'h2020, 32'h2020, 32'h2020, "diff after");

    wr(8'd1, 32'h1, 4'hF);
    wr(8'd2, 32'h2, 4'hF);
    wr(8'd3, 32'h3, 4'hF);
    rd_enb = 1'b1; rd_addr = 8'd1;
    cycle();
    rd_addr = 8'd2;
    check("b2b c1 u0", dout[0], 32'h1);
    check("b2b c1 u2 valid", 32'(vld[2]), 32'd0);
    cycle();
    rd_addr = 8'd3;
    check("b2b c2 u0", dout[0], 32'h2);
    check("b2b c2 u2 valid", 32'(vld[2]), 32'd1);
    check("b2b c2 u2", dout[2], 32'h1);
    cycle();
    rd_enb = 1'b0;
    check("b2b c3 u0", dout[0], 32'h3);
    check("b2b c3 u2 valid", 32'(vld[2]), 32'd1);
    check("b2b c3 u2", dout[2], 32'h2);
    cycle();
    check("b2b c4 u0 valid", 32'(vld[0]), 32'd0);
    check("b2b c4 u0 hold", dout[0], 32'h3);
    check("b2b c4 u2 valid", 32'(vld[2]), 32'd1);
    check("b2b c4 u2", dout[2], 32'h3);
    cycle();
    check("b2b c5 u2 valid", 32'(vld[2]), 32'd0);
    check("b2b c5 u2 hold", dout[2], 32'h3);

    wr(8'd199, 32'h199, 4'hF);
    wr(8'd210, 32'h5, 4'hF);
    read_all(8'd210, 32'h5, 32'h5, 32'h5, 32'h0, "oor 210");
    read_all(8'd199, 32'h199, 32'h199, 32'h199, 32'h199, "oor 199");

    rd_addr = 8'd5; rd_enb = 1'b1;
    cycle();
    rd_enb = 1'b0; reset = 1'b0;
    cycle();
    check("inflight u2 valid", 32'(vld[2]), 32'd0);
    check("inflight u2 data", dout[2], 32'd0);
    check("inflight u0 data", dout[0], 32'd0);
    reset = 1'b1;
    repeat (100) cycle();
    check("mid clear busy", 32'(busy[0]), 32'd1);
    reset = 1'b0;
    cycle();
    check("mid reset busy 1", 32'(busy[0]), 32'd1);
    cycle();
    check("mid reset busy 2", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    wait_clear(50, c0, c3, spur);
    check("restart len 256", c0, 256);
    check("restart len 200", c3, 200);
    check("busy no rd_valid", spur, 0);
    read_all(8'd12, '0, '0, '0, '0, "busy write dropped");
    read_all(8'd5,  '0, '0, '0, '0, "restart cleared");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
